// File: rtl/voice_id_sequencer.sv
// voice_id_sequencer
//   Collects voice-prompt IDs received as UART bytes into a small buffer,
//   then plays them back one at a time as BCD digit pairs. After each
//   accepted entry there is an idle gap of HOLD_CYCLES clocks.
//
//   Byte tokens: 0 ABORT, 5 BEGIN, 46 END, 47 AGAIN,
//                1..4 and 6..45 RECORD, 48..255 ignored.
//
// Ports
//   clk        system clock, rising edge
//   nRESET     asynchronous active-low reset
//   rx_data    received byte, sampled when rx_valid=1
//   rx_valid   single-cycle strobe for rx_data
//   out_valid  display entry available (registered)
//   out_ready  display stage accepts the entry when out_valid=1
//   out_tens   BCD tens digit of the presented ID (registered)
//   out_ones   BCD ones digit of the presented ID (registered)
//   state      0 IDLE, 1 COLLECT, 2 PLAY, 3 DONE
//   count      number of valid buffer entries, 0..DEPTH
//   overflow   sticky: a RECORD was dropped because the buffer was full
module voice_id_sequencer #(
    parameter int unsigned DEPTH       = 8,
    parameter int unsigned HOLD_CYCLES = 16
) (
    input  logic       clk,
    input  logic       nRESET,
    input  logic [7:0] rx_data,
    input  logic       rx_valid,
    output logic       out_valid,
    input  logic       out_ready,
    output logic [3:0] out_tens,
    output logic [3:0] out_ones,
    output logic [1:0] state,
    output logic [4:0] count,
    output logic       overflow
);

    localparam int unsigned IDX_W  = $clog2(DEPTH);
    localparam int unsigned HOLD_W = $clog2(HOLD_CYCLES + 1);
    localparam logic [4:0]        DEPTH_C = 5'(DEPTH);
    localparam logic [HOLD_W-1:0] HOLD_C  = HOLD_W'(HOLD_CYCLES);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_COLLECT = 2'd1,
        S_PLAY    = 2'd2,
        S_DONE    = 2'd3
    } state_t;

    state_t            st;
    logic [5:0]        id_mem [DEPTH];
    logic [4:0]        rd_idx;
    logic [HOLD_W-1:0] hold_cnt;

    logic tok_abort, tok_begin, tok_end, tok_again, tok_record;
    logic clr_buf, wr_buf;

    assign state = st;

    // IDs are at most 45, so a short subtract chain replaces a divider.
    function automatic logic [7:0] to_bcd(input logic [5:0] id);
        logic [3:0] t;
        logic [3:0] o;
        if (id >= 6'd40) begin
            t = 4'd4; o = 4'(id - 6'd40);
        end else if (id >= 6'd30) begin
            t = 4'd3; o = 4'(id - 6'd30);
        end else if (id >= 6'd20) begin
            t = 4'd2; o = 4'(id - 6'd20);
        end else if (id >= 6'd10) begin
            t = 4'd1; o = 4'(id - 6'd10);
        end else begin
            t = 4'd0; o = 4'(id);
        end
        return {t, o};
    endfunction

    always_comb begin
        tok_abort  = rx_valid && (rx_data == 8'd0);
        tok_begin  = rx_valid && (rx_data == 8'd5);
        tok_end    = rx_valid && (rx_data == 8'd46);
        tok_again  = rx_valid && (rx_data == 8'd47);
        tok_record = rx_valid &&
                     (((rx_data >= 8'd1) && (rx_data <= 8'd4)) ||
                      ((rx_data >= 8'd6) && (rx_data <= 8'd45)));
        clr_buf    = ((st == S_IDLE)    && tok_begin) ||
                     ((st == S_COLLECT) && tok_begin) ||
                     ((st == S_DONE)    && tok_again);
        wr_buf     = (st == S_COLLECT) && tok_record && (count < DEPTH_C);
    end

    // Buffer storage has no reset; contents are only meaningful below count.
    always_ff @(posedge clk) begin
        if (clr_buf) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                id_mem[i] <= '0;
            end
        end else if (wr_buf) begin
            id_mem[count[IDX_W-1:0]] <= rx_data[5:0];
        end
    end

    always_ff @(posedge clk or negedge nRESET) begin
        if (!nRESET) begin
            st        <= S_IDLE;
            count     <= '0;
            overflow  <= 1'b0;
            out_valid <= 1'b0;
            out_tens  <= '0;
            out_ones  <= '0;
            rd_idx    <= '0;
            hold_cnt  <= '0;
        end else begin
            case (st)
                S_IDLE: begin
                    if (tok_begin) begin
                        count    <= '0;
                        overflow <= 1'b0;
                        st       <= S_COLLECT;
                    end
                end

                S_COLLECT: begin
                    if (tok_abort) begin
                        st <= S_IDLE;
                    end else if (tok_begin) begin
                        count    <= '0;
                        overflow <= 1'b0;
                    end else if (tok_record) begin
                        if (count < DEPTH_C) begin
                            count <= count + 5'd1;
                        end else begin
                            overflow <= 1'b1;
                        end
                    end else if (tok_end) begin
                        if (count != '0) begin
                            st        <= S_PLAY;
                            rd_idx    <= '0;
                            hold_cnt  <= '0;
                            out_valid <= 1'b1;
                            {out_tens, out_ones} <= to_bcd(id_mem[0]);
                        end else begin
                            st <= S_DONE;
                        end
                    end
                end

                S_PLAY: begin
                    if (tok_abort) begin
                        st        <= S_IDLE;
                        out_valid <= 1'b0;
                        hold_cnt  <= '0;
                        rd_idx    <= '0;
                    end else if (out_valid && out_ready) begin
                        // rd_idx advances at the handshake; the hold expiry
                        // either presents that entry or finishes the run.
                        out_valid <= 1'b0;
                        hold_cnt  <= HOLD_C;
                        rd_idx    <= rd_idx + 5'd1;
                    end else if (hold_cnt != '0) begin
                        hold_cnt <= hold_cnt - HOLD_W'(1);
                        if (hold_cnt == HOLD_W'(1)) begin
                            if (rd_idx == count) begin
                                st <= S_DONE;
                            end else begin
                                out_valid <= 1'b1;
                                {out_tens, out_ones} <= to_bcd(id_mem[rd_idx[IDX_W-1:0]]);
                            end
                        end
                    end
                end

                S_DONE: begin
                    if (tok_abort) begin
                        st <= S_IDLE;
                    end else if (tok_again) begin
                        count    <= '0;
                        overflow <= 1'b0;
                        st       <= S_COLLECT;
                    end else if (tok_end && (count != '0)) begin
                        st        <= S_PLAY;
                        rd_idx    <= '0;
                        hold_cnt  <= '0;
                        out_valid <= 1'b1;
                        {out_tens, out_ones} <= to_bcd(id_mem[0]);
                    end
                end

                default: st <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_voice_id_sequencer.sv
// tb_voice_id_sequencer
//   Directed bench for voice_id_sequencer (DEPTH=8, HOLD_CYCLES=16).
//   A table of bytes with expected state/count/overflow, followed by
//   hand-written playback, back-pressure, abort and reset sequences.
module tb_voice_id_sequencer;

    logic       clk = 1'b0;
    logic       nRESET;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       out_valid;
    logic       out_ready;
    logic [3:0] out_tens;
    logic [3:0] out_ones;
    logic [1:0] state;
    logic [4:0] count;
    logic       overflow;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    // playback capture
    logic [7:0] rec_val [16];
    int         rec_cyc [16];
    int         rec_n;

    typedef struct packed {
        logic [7:0] b;
        logic [1:0] st;
        logic [4:0] cnt;
        logic       ovf;
    } vec_t;

    vec_t tbl [25];

    voice_id_sequencer #(
        .DEPTH       (8),
        .HOLD_CYCLES (16)
    ) dut (
        .clk       (clk),
        .nRESET    (nRESET),
        .rx_data   (rx_data),
        .rx_valid  (rx_valid),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_tens  (out_tens),
        .out_ones  (out_ones),
        .state     (state),
        .count     (count),
        .overflow  (overflow)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b);
        rx_data  = b;
        rx_valid = 1'b1;
        tick();
        rx_valid = 1'b0;
        rx_data  = 8'hFF;
    endtask

    task automatic do_reset();
        rx_valid  = 1'b0;
        rx_data   = 8'hFF;
        out_ready = 1'b0;
        nRESET    = 1'b0;
        repeat (2) tick();
        nRESET = 1'b1;
        tick();
    endtask

    // Record every presented entry (sampled on negedge) until DONE is seen.
    task automatic run_until_done(input int budget);
        rec_n = 0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (out_valid && rec_n < 16) begin
                rec_val[rec_n] = {out_tens, out_ones};
                rec_cyc[rec_n] = cyc;
                rec_n++;
            end
            if (state == 2'd3) break;
        end
        check("reach_done", state, 2'd3);
    endtask

    initial begin
        logic [7:0] exp_e [8];
        int bad;

        tbl[0]  = '{8'd48,  2'd0, 5'd0, 1'b0};
        tbl[1]  = '{8'd200, 2'd0, 5'd0, 1'b0};
        tbl[2]  = '{8'd47,  2'd0, 5'd0, 1'b0};
        tbl[3]  = '{8'd5,   2'd1, 5'd0, 1'b0};
        tbl[4]  = '{8'd46,  2'd3, 5'd0, 1'b0};
        tbl[5]  = '{8'd47,  2'd1, 5'd0, 1'b0};
        tbl[6]  = '{8'd1,   2'd1, 5'd1, 1'b0};
        tbl[7]  = '{8'd4,   2'd1, 5'd2, 1'b0};
        tbl[8]  = '{8'd6,   2'd1, 5'd3, 1'b0};
        tbl[9]  = '{8'd45,  2'd1, 5'd4, 1'b0};
        tbl[10] = '{8'd47,  2'd1, 5'd4, 1'b0};
        tbl[11] = '{8'd99,  2'd1, 5'd4, 1'b0};
        tbl[12] = '{8'd5,   2'd1, 5'd0, 1'b0};
        tbl[13] = '{8'd10,  2'd1, 5'd1, 1'b0};
        tbl[14] = '{8'd11,  2'd1, 5'd2, 1'b0};
        tbl[15] = '{8'd12,  2'd1, 5'd3, 1'b0};
        tbl[16] = '{8'd13,  2'd1, 5'd4, 1'b0};
        tbl[17] = '{8'd14,  2'd1, 5'd5, 1'b0};
        tbl[18] = '{8'd15,  2'd1, 5'd6, 1'b0};
        tbl[19] = '{8'd16,  2'd1, 5'd7, 1'b0};
        tbl[20] = '{8'd17,  2'd1, 5'd8, 1'b0};
        tbl[21] = '{8'd20,  2'd1, 5'd8, 1'b1};
        tbl[22] = '{8'd0,   2'd0, 5'd8, 1'b1};
        tbl[23] = '{8'd5,   2'd1, 5'd0, 1'b0};
        tbl[24] = '{8'd46,  2'd3, 5'd0, 1'b0};

        // Reset state
        do_reset();
        check("rst_state", state, 2'd0);
        check("rst_count", count, 5'd0);
        check("rst_ovf", overflow, 1'b0);
        check("rst_valid", out_valid, 1'b0);
        check("rst_digits", {out_tens, out_ones}, 8'h00);

        // Token table, out_ready=0 throughout
        for (int i = 0; i < 25; i++) begin
            send_byte(tbl[i].b);
            check($sformatf("vec%0d_state", i), state, tbl[i].st);
            check($sformatf("vec%0d_count", i), count, tbl[i].cnt);
            check($sformatf("vec%0d_ovf", i), overflow, tbl[i].ovf);
            check($sformatf("vec%0d_valid", i), out_valid, 1'b0);
        end

        // Basic playback with 17-cycle handshake spacing
        do_reset();
        out_ready = 1'b1;
        send_byte(8'd5); send_byte(8'd13); send_byte(8'd35); send_byte(8'd44);
        send_byte(8'd46);
        check("play_state", state, 2'd2);
        run_until_done(200);
        check("play_n", rec_n, 3);
        exp_e[0] = 8'h13; exp_e[1] = 8'h35; exp_e[2] = 8'h44;
        for (int i = 0; i < 3 && i < rec_n; i++)
            check($sformatf("play_e%0d", i), rec_val[i], exp_e[i]);
        if (rec_n >= 3) begin
            check("gap01", rec_cyc[1] - rec_cyc[0], 17);
            check("gap12", rec_cyc[2] - rec_cyc[1], 17);
        end
        check("play_count", count, 5'd3);
        check("play_end_valid", out_valid, 1'b0);

        // AGAIN from DONE, new IDs, then ABORT
        send_byte(8'd47);
        check("again_state", state, 2'd1);
        check("again_count", count, 5'd0);
        send_byte(8'd30); send_byte(8'd38); send_byte(8'd46);
        run_until_done(200);
        check("again_n", rec_n, 2);
        exp_e[0] = 8'h30; exp_e[1] = 8'h38;
        for (int i = 0; i < 2 && i < rec_n; i++)
            check($sformatf("again_e%0d", i), rec_val[i], exp_e[i]);
        send_byte(8'd0);
        check("again_abort_state", state, 2'd0);
        check("again_abort_count", count, 5'd2);

        // Overflow: ninth RECORD dropped, first eight played
        do_reset();
        out_ready = 1'b1;
        send_byte(8'd5);
        send_byte(8'd1);  send_byte(8'd12); send_byte(8'd23); send_byte(8'd34);
        send_byte(8'd45); send_byte(8'd6);  send_byte(8'd19); send_byte(8'd40);
        send_byte(8'd41);
        check("ovf_count", count, 5'd8);
        check("ovf_flag", overflow, 1'b1);
        send_byte(8'd46);
        run_until_done(400);
        check("ovf_n", rec_n, 8);
        exp_e[0] = 8'h01; exp_e[1] = 8'h12; exp_e[2] = 8'h23; exp_e[3] = 8'h34;
        exp_e[4] = 8'h45; exp_e[5] = 8'h06; exp_e[6] = 8'h19; exp_e[7] = 8'h40;
        for (int i = 0; i < 8 && i < rec_n; i++)
            check($sformatf("ovf_e%0d", i), rec_val[i], exp_e[i]);
        // Replay from DONE with END
        send_byte(8'd46);
        check("replay_state", state, 2'd2);
        check("replay_first", {out_valid, out_tens, out_ones}, 9'h101);

        // Back-pressure: entry held for 50 cycles
        do_reset();
        send_byte(8'd5); send_byte(8'd27); send_byte(8'd46);
        check("bp_valid", out_valid, 1'b1);
        check("bp_digits", {out_tens, out_ones}, 8'h27);
        bad = 0;
        for (int i = 0; i < 50; i++) begin
            tick();
            if (out_valid !== 1'b1 || {out_tens, out_ones} !== 8'h27) bad++;
        end
        check("bp_hold_bad_cycles", bad, 0);
        out_ready = 1'b1;
        tick();
        check("bp_accept_valid", out_valid, 1'b0);
        check("bp_digits_held", {out_tens, out_ones}, 8'h27);
        repeat (15) tick();
        check("bp_final_hold_state", state, 2'd2);
        check("bp_final_hold_valid", out_valid, 1'b0);
        tick();
        check("bp_done_state", state, 2'd3);

        // ABORT coinciding with a handshake
        do_reset();
        out_ready = 1'b1;
        send_byte(8'd5); send_byte(8'd11); send_byte(8'd22); send_byte(8'd46);
        check("ab_valid_pre", out_valid, 1'b1);
        send_byte(8'd0);
        check("ab_state", state, 2'd0);
        check("ab_valid", out_valid, 1'b0);
        bad = 0;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (out_valid !== 1'b0) bad++;
        end
        check("ab_no_more_entries", bad, 0);
        check("ab_count", count, 5'd2);

        // Reset pulsed mid-PLAY takes effect without a clock edge
        out_ready = 1'b0;
        send_byte(8'd5); send_byte(8'd11); send_byte(8'd22); send_byte(8'd46);
        check("rp_valid_pre", out_valid, 1'b1);
        #2;
        nRESET = 1'b0;
        #1;
        check("rp_state", state, 2'd0);
        check("rp_valid", out_valid, 1'b0);
        check("rp_count", count, 5'd0);
        check("rp_digits", {out_tens, out_ones}, 8'h00);
        @(negedge clk);
        nRESET = 1'b1;
        send_byte(8'd46);
        check("rp_end_ignored", state, 2'd0);
        send_byte(8'd5);
        check("rp_begin", state, 2'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
